// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, ALUOp and M-extension funct3 encodings, and the
// multiply/divide sequencer state type shared by alu_ctrl_mdu and mdu_iter.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    // Branch compare reuses the XOR code.
    localparam logic [3:0] ALU_BRANCH = ALU_XOR;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one-bit-per-cycle multiply/divide datapath working on operand magnitudes,
// with the sign applied combinationally to the final iteration's result.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    logic              running;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   b_reg;
    logic [2*XLEN-1:0] p;
    logic [2*XLEN-1:0] p_next;

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic            sign_res;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F3_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg    = a_signed && op_a[XLEN-1];
        b_neg    = b_signed && op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        // A remainder takes the dividend's sign; everything else the product of signs.
        sign_res = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
    end

    // p holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
    logic [XLEN:0] mul_sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        mul_sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b_reg} : '0);
        shifted = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        diff    = shifted - {1'b0, b_reg};
        if (op[2]) begin
            if (!diff[XLEN])
                p_next = {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
            else
                p_next = {shifted[XLEN-1:0], p[XLEN-2:0], 1'b0};
        end else begin
            p_next = {mul_sum, p[XLEN-1:1]};
        end
    end

    assign done = running && (cnt == CNT_W'(XLEN - 1));

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    always_comb begin
        prod = neg ? -p_next : p_next;
        quo  = neg ? -p_next[XLEN-1:0] : p_next[XLEN-1:0];
        rem  = neg ? -p_next[2*XLEN-1:XLEN] : p_next[2*XLEN-1:XLEN];
        case (op)
            F3_MUL:                        result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  result = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               result = quo;
            default:                       result = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
            op      <= '0;
            neg     <= 1'b0;
            b_reg   <= '0;
            p       <= '0;
        end else if (kill) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            op      <= funct3;
            neg     <= sign_res;
            b_reg   <= b_mag;
            p       <= {{XLEN{1'b0}}, a_mag};
        end else if (running) begin
            p <= p_next;
            if (done) begin
                running <= 1'b0;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: RV32 ALU control decoder with an optional multi-cycle multiply/divide unit.
// Define ALU_MEXT_EN to build in the M-extension sequencer and the mdu_iter datapath.
module alu_ctrl_mdu
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              stall,
    output logic              md_valid,
    input  logic              md_ready,
    output logic [XLEN-1:0]   md_result
);
    logic       m_op;
    logic [3:0] code;

`ifdef ALU_MEXT_EN
    assign m_op = (ALUOp == ALUOP_RTYPE) && (funct7 == FUNCT7_MEXT);
`else
    assign m_op = 1'b0;
`endif

    // I-type has no SUB; only its shift-right group looks at funct7[5] to pick SRA.
    always_comb begin
        code = ALU_ADD;
        case (ALUOp)
            ALUOP_MEM:    code = ALU_ADD;
            ALUOP_BRANCH: code = ALU_BRANCH;
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3)
                    3'b000:  code = (ALUOp == ALUOP_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
                if (m_op)
                    code = ALU_ADD;
            end
            default: code = ALU_ADD;
        endcase
    end

    assign ALUControl = CTRL_W'(code);

`ifdef ALU_MEXT_EN
    mdu_state_t      state;
    mdu_state_t      state_next;
    logic            accept;
    logic            fast;
    logic            start;
    logic            div_zero;
    logic            div_ovf;
    logic            iter_done;
    logic [XLEN-1:0] iter_result;
    logic [XLEN-1:0] fast_result;
    logic [XLEN-1:0] int_min;

    // Divide-by-zero and signed overflow bypass the iterative datapath entirely.
    assign int_min  = {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (op_a == int_min) && (op_b == '1);
    assign fast     = div_zero || div_ovf;

    always_comb begin
        fast_result = '0;
        if (div_zero)
            fast_result = funct3[1] ? op_a : '1;
        else if (div_ovf)
            fast_result = funct3[1] ? '0 : op_a;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && m_op) begin
                    accept     = 1'b1;
                    state_next = fast ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (iter_done)
                    state_next = DONE;
            end
            DONE: begin
                if (md_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            accept     = 1'b0;
            state_next = IDLE;
        end
    end

    assign start = accept && !fast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            md_result <= '0;
        end else begin
            state <= state_next;
            if (accept && fast)
                md_result <= fast_result;
            else if (state == BUSY && iter_done && !flush)
                md_result <= iter_result;
        end
    end

    mdu_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .kill   (flush),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .done   (iter_done),
        .result (iter_result)
    );

    assign in_ready = (state == IDLE);
    assign md_valid = (state == DONE);
    assign stall    = in_valid && m_op && !(state == DONE && md_ready);
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, op_a, op_b, in_valid, flush, md_ready,
                             funct7[6], funct7[4:0], m_op};

    assign in_ready  = 1'b1;
    assign stall     = 1'b0;
    assign md_valid  = 1'b0;
    assign md_result = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: randomized self-checking bench for alu_ctrl_mdu against an
// arithmetic reference model; covers both the ALU_MEXT_EN and the plain decoder build.
module tb_alu_ctrl_mdu;
    localparam int XLEN = 32;

    logic        clk;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [3:0]  alu_control;
    logic        stall;
    logic        md_valid;
    logic        md_ready;
    logic [31:0] md_result;

    int total = 0;
    int bad   = 0;

    alu_ctrl_mdu #(
        .XLEN   (XLEN),
        .CTRL_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .op_a       (op_a),
        .op_b       (op_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .ALUControl (alu_control),
        .stall      (stall),
        .md_valid   (md_valid),
        .md_ready   (md_ready),
        .md_result  (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

`ifdef ALU_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    // Mnemonic order per funct3: ADD SLL SLT SLTU XOR SRL OR AND, and the funct7[5] variants.
    localparam logic [3:0] PLAIN_CODES [8] = '{4'd2, 4'd4, 4'd7, 4'd8, 4'd3, 4'd5, 4'd1, 4'd0};
    localparam logic [3:0] ALT_CODES   [8] = '{4'd6, 4'd4, 4'd7, 4'd8, 4'd3, 4'd9, 4'd1, 4'd0};

    logic [6:0] f7_set [3] = '{7'h00, 7'h20, 7'h01};

    function automatic logic [3:0] ref_code(input logic [1:0] aop, input logic [2:0] f3,
                                            input logic [6:0] f7);
        bit use_alt;
        if (aop == 2'b00) return 4'd2;
        if (aop == 2'b01) return 4'd3;
        if (MEXT && aop == 2'b10 && f7 == 7'h01) return 4'd2;
        use_alt = f7[5] && ((aop == 2'b10) || (f3 == 3'd5));
        return use_alt ? ALT_CODES[f3] : PLAIN_CODES[f3];
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ub;
        logic [63:0] prod;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ub = longint'({32'd0, b});
        case (f3)
            3'd0: begin prod = 64'(sa * sb); return prod[31:0]; end
            3'd1: begin prod = 64'(sa * sb); return prod[63:32]; end
            3'd2: begin prod = 64'(sa * ub); return prod[63:32]; end
            3'd3: begin prod = {32'd0, a} * {32'd0, b}; return prod[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit ref_fast(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issues one M op from a negedge, scrambles operands after accept, waits for
    // md_valid, optionally holds md_ready low, then retires it; ends on a negedge.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input int hold);
        logic [31:0] exp_res;
        logic [31:0] first_res;
        int          exp_lat;
        int          lat;
        bit          seen;
        bit          busy_ok;
        bit          hold_ok;
        exp_res = ref_md(f3, a, b);
        exp_lat = ref_fast(f3, a, b) ? 1 : XLEN + 1;
        in_valid = 1'b1;
        alu_op   = 2'b10;
        funct7   = 7'h01;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        md_ready = 1'b0;
        flush    = 1'b0;
        #1;
        checkOutput($sformatf("stall_on_issue f3=%0d", f3), {in_ready, stall}, 2'b11);
        lat     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && lat < XLEN + 8) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            op_a = $urandom;
            op_b = $urandom;
            if (md_valid)
                seen = 1'b1;
            else if (!stall || in_ready)
                busy_ok = 1'b0;
        end
        checkOutput($sformatf("latency f3=%0d", f3), lat, exp_lat);
        checkOutput($sformatf("busy_stall f3=%0d", f3), busy_ok, 1'b1);
        checkOutput($sformatf("result f3=%0d a=%0h b=%0h", f3, a, b), md_result, exp_res);
        first_res = md_result;
        hold_ok   = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!md_valid || in_ready || !stall || md_result !== first_res)
                hold_ok = 1'b0;
        end
        if (hold > 0)
            checkOutput("done_hold_stable", hold_ok, 1'b1);
        md_ready = 1'b1;
        #1;
        checkOutput("stall_release", stall, 1'b0);
        @(negedge clk);
        checkOutput("retire_idle", {md_valid, in_ready}, 2'b01);
        in_valid = 1'b0;
        md_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        md_ready = 1'b0;
        alu_op   = 2'b00;
        funct3   = 3'd0;
        funct7   = 7'd0;
        op_a     = 32'd0;
        op_b     = 32'd0;
        #1;
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_md_valid", md_valid, 1'b0);
        checkOutput("reset_md_result", md_result, 32'd0);
        checkOutput("reset_stall", stall, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 8; f++) begin
                for (int k = 0; k < 3; k++) begin
                    alu_op = 2'(op);
                    funct3 = 3'(f);
                    funct7 = f7_set[k];
                    #1;
                    checkOutput($sformatf("decode op=%0d f3=%0d f7=%0h", op, f, f7_set[k]),
                                alu_control, ref_code(alu_op, funct3, funct7));
                end
            end
        end
        for (int n = 0; n < 100; n++) begin
            alu_op = 2'($urandom);
            funct3 = 3'($urandom);
            funct7 = 7'($urandom);
            #1;
            checkOutput($sformatf("rand_decode op=%0d f3=%0d f7=%0h", alu_op, funct3, funct7),
                        alu_control, ref_code(alu_op, funct3, funct7));
        end

`ifdef ALU_MEXT_EN
        begin
            bit          seen;
            logic [2:0]  f3r;
            logic [31:0] ar;
            logic [31:0] br;
            @(negedge clk);
            applyStimulus(3'd0, 32'hFFFF_FFFF, 32'd2, 0);
            applyStimulus(3'd3, 32'hFFFF_FFFF, 32'd2, 0);
            applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, 5);
            applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
            applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
            applyStimulus(3'd5, 32'd5, 32'd0, 2);
            applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
            applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
            applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
            for (int n = 0; n < 40; n++) begin
                f3r = 3'($urandom_range(0, 7));
                ar  = $urandom;
                br  = $urandom;
                case ($urandom_range(0, 5))
                    0: br = 32'd0;
                    1: br = 32'hFFFF_FFFF;
                    2: br = 32'($urandom_range(1, 15));
                    default: ;
                endcase
                if ($urandom_range(0, 7) == 0)
                    ar = 32'h8000_0000;
                applyStimulus(f3r, ar, br, $urandom_range(0, 2));
            end

            in_valid = 1'b1;
            alu_op   = 2'b10;
            funct7   = 7'h01;
            funct3   = 3'd0;
            flush    = 1'b1;
            @(negedge clk);
            checkOutput("flush_beats_accept", in_ready, 1'b1);
            flush  = 1'b0;
            op_a   = $urandom;
            op_b   = $urandom;
            @(negedge clk);
            repeat (9) @(negedge clk);
            checkOutput("busy_before_flush", {in_ready, md_valid}, 2'b00);
            flush    = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            flush = 1'b0;
            checkOutput("flush_busy_idle", {md_valid, in_ready}, 2'b01);
            seen = 1'b0;
            repeat (XLEN + 4) begin
                @(negedge clk);
                if (md_valid) seen = 1'b1;
            end
            checkOutput("flush_no_late_valid", seen, 1'b0);

            in_valid = 1'b1;
            funct3   = 3'd5;
            op_a     = 32'h1234_5678;
            op_b     = 32'd0;
            @(negedge clk);
            checkOutput("fast_path_valid", md_valid, 1'b1);
            flush    = 1'b1;
            md_ready = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            flush    = 1'b0;
            md_ready = 1'b0;
            checkOutput("flush_done_idle", {md_valid, in_ready}, 2'b01);

            in_valid = 1'b1;
            funct3   = 3'd0;
            op_a     = 32'd7;
            op_b     = 32'd9;
            @(negedge clk);
            repeat (4) @(negedge clk);
            rst_n = 1'b0;
            #1;
            checkOutput("midop_reset_md_result", md_result, 32'd0);
            checkOutput("midop_reset_flags", {md_valid, in_ready}, 2'b01);
            in_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            seen  = 1'b0;
            repeat (XLEN + 4) begin
                @(negedge clk);
                if (md_valid) seen = 1'b1;
            end
            checkOutput("reset_discards_op", seen, 1'b0);
        end
`else
        begin
            bit flags_ok;
            @(negedge clk);
            in_valid = 1'b1;
            alu_op   = 2'b10;
            funct7   = 7'h01;
            funct3   = 3'd4;
            op_a     = $urandom;
            op_b     = $urandom;
            #1;
            checkOutput("nomext_xor_code", alu_control, 4'd3);
            checkOutput("nomext_flags", {stall, md_valid, in_ready}, 3'b001);
            checkOutput("nomext_md_result", md_result, 32'd0);
            flags_ok = 1'b1;
            repeat (40) begin
                @(negedge clk);
                in_valid = 1'($urandom);
                flush    = 1'($urandom);
                md_ready = 1'($urandom);
                funct3   = 3'($urandom);
                op_a     = $urandom;
                op_b     = $urandom;
                #1;
                if (stall || md_valid || !in_ready || md_result !== 32'd0)
                    flags_ok = 1'b0;
            end
            checkOutput("nomext_flags_constant", flags_ok, 1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (>=8, even).
REQ-002 SHALL have parameter CTRL_W, default 4, ALU control code width (>=4).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
REQ-006 SHALL have ports: funct3  in  3  instruction[14:12].
REQ-007 SHALL have ports: funct7  in  7  instruction[31:25].
REQ-008 SHALL have ports: op_a, op_b  in  XLEN  rs1/rs2 operands for M ops.
REQ-009 SHALL have ports: in_valid  in  1  decode inputs valid; in_ready  out  1  M op may be accepted.
REQ-010 SHALL have ports: flush  in  1  kill any in-flight M op.
REQ-011 SHALL have ports: ALUControl  out  CTRL_W  combinational ALU code, zero-extended 4-bit encoding.
REQ-012 SHALL have ports: stall  out  1  hold pipeline; md_valid  out  1; md_ready  in  1; md_result  out  XLEN.

Function
REQ-013 ALUControl: ALUOp 00 -> 0010; 01 -> 0011; default/unknown -> 0010.
REQ-014 ALUOp 10, funct3 000..111 -> ADD 0010/SUB 0110 (funct7[5]), SLL 0100, SLT 0111, SLTU 1000, XOR 0011, SRL 0101/SRA 1001 (funct7[5]), OR 0001, AND 0000.
REQ-015 ALUOp 11 SHALL decode as ALUOp 10 except funct3 000 always ADD; funct7[5] honoured only for funct3 101.
REQ-016 M op = ALUOp 10 and funct7 == 0000001; funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; ALUControl for M op SHALL be 0010.
REQ-017 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE).
REQ-018 IDLE: in_valid & M op -> latch operands/funct3, next BUSY (or DONE for fast path); non-M ops never leave IDLE.
REQ-019 BUSY: one iteration per cycle, exactly XLEN cycles (shift-add multiply, restoring divide on magnitudes, sign fixed at end), then DONE.
REQ-020 DONE: md_valid=1, md_result stable; md_ready -> IDLE same edge; new op accepted no earlier than following cycle.
REQ-021 Latency: accept edge to md_valid = XLEN+1 cycles; fast path = 1 cycle.
REQ-022 Fast path: divide by zero -> DIV/DIVU quotient all-ones, REM/REMU = op_a; DIV/REM of -2^(XLEN-1) by -1 -> quotient op_a, remainder 0.
REQ-023 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of 2*XLEN product with signed/signed, signed/unsigned, unsigned/unsigned operands.
REQ-024 stall = in_valid & M op & !(state==DONE & md_ready).
REQ-025 flush in any state -> IDLE next edge, md_valid 0; flush wins over simultaneous accept or md_ready.
REQ-026 Operand changes after accept SHALL not affect the in-flight result.

Reset
REQ-027 rst_n low asynchronously forces IDLE, md_valid 0, md_result 0, iteration counter 0, latched operands 0; mid-operation reset discards the op.

Configuration
REQ-028 Macro ALU_MEXT_EN defined: M ops and MDU as above.
REQ-029 ALU_MEXT_EN undefined: funct7 0000001 decodes per REQ-014 with funct7[5]=0; in_ready=1, stall=0, md_valid=0, md_result=0; no FSM or datapath.

Structure
REQ-030 Shared package alu_pkg SHALL hold ALU code constants, ALUOp encodings, M funct3 encodings, FSM state typedef.
REQ-031 Iterative datapath SHALL be sub-module mdu_iter (start, funct3, operands, done, result); decode and FSM stay in alu_ctrl_mdu.

Verification
REQ-032 Full decode sweep ALUOp x funct3 x funct7{0000000,0100000} -> codes per REQ-013..015; ALUOp 11 funct3 000 funct7 0100000 -> 0010.
REQ-033 XLEN=32 MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE; MULHU same -> 0x00000001; MULH -> 0xFFFFFFFF; md_valid at cycle 33, stall high until DONE&md_ready.
REQ-034 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF in 1 cycle; DIV 0x80000000/-1 -> 0x80000000, REM 0.
REQ-035 md_ready held low 5 cycles in DONE -> md_valid and md_result stable; in_ready low throughout.
REQ-036 flush at BUSY cycle 10 -> IDLE next cycle, no md_valid; rst_n low at cycle 5 -> all outputs reset immediately.
REQ-037 Build without ALU_MEXT_EN: funct7 0000001 funct3 100 -> ALUControl 0011, stall 0, md_valid 0.
